bus_arb2_rtrack: RTL and testbench

//  Two-master arbiter with read-response tracking. Sits between the debug master (udm, m0)
//  and the CPU data port (m1) on one side, and the bus unit's data port (s) on the other.

---
 rtl/bus_arb2_rtrack.sv | 154 +++++++++++++++
 tb/tb_bus_arb2_rtrack.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2_rtrack.sv
// Two-master bus arbiter with in-order read-response tracking.
// m0 (debug master) normally wins over m1 (CPU data port); a starvation
// counter forces one m1 grant after MAX_BURST consecutive m0 grants while
// m1 waits. Every accepted read pushes the granted master ID into a tag
// FIFO so the in-order responses from the bus unit return to their owner.
module bus_arb2_rtrack #(
    parameter int RD_DEPTH  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    input  logic                        m0_req_i,
    input  logic                        m0_we_i,
    input  logic [31:0]                 m0_addr_bi,
    input  logic [3:0]                  m0_be_bi,
    input  logic [31:0]                 m0_wdata_bi,
    output logic                        m0_ack_o,
    output logic                        m0_resp_o,
    output logic [31:0]                 m0_rdata_bo,
    input  logic                        m1_req_i,
    input  logic                        m1_we_i,
    input  logic [31:0]                 m1_addr_bi,
    input  logic [3:0]                  m1_be_bi,
    input  logic [31:0]                 m1_wdata_bi,
    output logic                        m1_ack_o,
    output logic                        m1_resp_o,
    output logic [31:0]                 m1_rdata_bo,
    output logic                        s_req_o,
    output logic                        s_we_o,
    output logic [31:0]                 s_addr_bo,
    output logic [3:0]                  s_be_bo,
    output logic [31:0]                 s_wdata_bo,
    input  logic                        s_ack_i,
    input  logic                        s_resp_i,
    input  logic [31:0]                 s_rdata_bi,
    output logic [$clog2(RD_DEPTH):0]   outstanding_bo,
    output logic                        err_o
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RD_DEPTH);
    localparam logic [SW-1:0] SAT_CNT  = SW'(MAX_BURST);

    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [RD_DEPTH-1:0] tags_q, tags_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                err_q, err_d;

    logic full, m0_cand, m1_cand, gnt0, gnt1;
    logic push, pop, orphan, head_id;

    // Arbitration and request mux; reset forces the bus side idle.
    always_comb begin
        full    = (count_q == FULL_CNT);
        // The full check uses only the registered count, so a same-cycle
        // pop does not unblock a read.
        m0_cand = arst_n_i & m0_req_i & (m0_we_i | ~full);
        m1_cand = arst_n_i & m1_req_i & (m1_we_i | ~full);
        gnt1    = m1_cand & ((starve_q == SAT_CNT) | ~m0_cand);
        gnt0    = m0_cand & ~gnt1;

        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        if (gnt0) begin
            s_req_o    = 1'b1;
            s_we_o     = m0_we_i;
            s_addr_bo  = m0_addr_bi;
            s_be_bo    = m0_be_bi;
            s_wdata_bo = m0_wdata_bi;
        end else if (gnt1) begin
            s_req_o    = 1'b1;
            s_we_o     = m1_we_i;
            s_addr_bo  = m1_addr_bi;
            s_be_bo    = m1_be_bi;
            s_wdata_bo = m1_wdata_bi;
        end
        m0_ack_o = gnt0 & s_ack_i;
        m1_ack_o = gnt1 & s_ack_i;
    end

    // Response routing off the FIFO head; responses with nothing in flight are dropped.
    always_comb begin
        head_id     = tags_q[rd_ptr_q];
        pop         = arst_n_i & s_resp_i & (count_q != '0);
        orphan      = arst_n_i & s_resp_i & (count_q == '0);
        m0_resp_o   = pop & ~head_id;
        m1_resp_o   = pop & head_id;
        m0_rdata_bo = m0_resp_o ? s_rdata_bi : 32'h0;
        m1_rdata_bo = m1_resp_o ? s_rdata_bi : 32'h0;
    end

    // Next-state for the tag FIFO, starvation counter and sticky error.
    always_comb begin
        push     = s_req_o & s_ack_i & ~s_we_o;
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            tags_d[wr_ptr_q] = gnt1;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (!m1_req_i || (gnt1 && s_ack_i)) begin
            starve_d = '0;
        end else if (gnt0 && s_ack_i && (starve_q != SAT_CNT)) begin
            starve_d = starve_q + SW'(1);
        end

        err_d = err_q | orphan;
    end

    // Control state; reset discards all tags in flight.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Tag storage; entries are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        tags_q <= tags_d;
    end

    assign outstanding_bo = count_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_bus_arb2_rtrack.sv
// Directed bench for bus_arb2_rtrack (RD_DEPTH=4, MAX_BURST=8).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_bus_arb2_rtrack;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
    logic [3:0]  m0_be_bi, m1_be_bi;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_bo, m1_rdata_bo;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_bo, s_wdata_bo;
    logic [3:0]  s_be_bo;
    logic        s_ack_i, s_resp_i;
    logic [31:0] s_rdata_bi;
    logic [2:0]  outstanding_bo;
    logic        err_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    bus_arb2_rtrack #(.RD_DEPTH(4), .MAX_BURST(8)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi),
        .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi),
        .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi),
        .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi),
        .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
        .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
        .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
        .outstanding_bo(outstanding_bo), .err_o(err_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic idle();
        m0_req_i = 0; m0_we_i = 0; m0_addr_bi = 0; m0_be_bi = 0; m0_wdata_bi = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_bi = 0; m1_be_bi = 0; m1_wdata_bi = 0;
        s_ack_i = 0; s_resp_i = 0; s_rdata_bi = 0;
    endtask

    task automatic test_reset();
        arst_n_i = 0;
        idle();
        m0_req_i = 1; m0_addr_bi = 32'h44; s_ack_i = 1;
        smp();
        n_chk++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_sreq got %b want 0", s_req_o); end
        n_chk++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_m0ack got %b want 0", m0_ack_o); end
        n_chk++; if (s_addr_bo !== 32'h0) begin n_fail++; $display("FAIL rst_saddr got %h want 0", s_addr_bo); end
        n_chk++; if (outstanding_bo !== 3'd0) begin n_fail++; $display("FAIL rst_outst got %0d want 0", outstanding_bo); end
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err_o); end
        cyc();
        idle();
        arst_n_i = 1;
        cyc();
    endtask

    task automatic test_single_read();
        m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h100; m0_be_bi = 4'hF; s_ack_i = 1;
        smp();
        n_chk++; if (s_req_o !== 1'b1 || s_addr_bo !== 32'h100 || s_we_o !== 1'b0) begin n_fail++; $display("FAIL t1_req got req=%b addr=%h we=%b want 1/100/0", s_req_o, s_addr_bo, s_we_o); end
        n_chk++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL t1_ack got %b%b want 10", m0_ack_o, m1_ack_o); end
        cyc();
        idle();
        smp();
        n_chk++; if (outstanding_bo !== 3'd1 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL t1_outst got %0d ack=%b want 1 ack=0", outstanding_bo, m0_ack_o); end
        cyc();
        s_resp_i = 1; s_rdata_bi = 32'hDEADBEEF;
        smp();
        n_chk++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_resp got %b %h want 1 deadbeef", m0_resp_o, m0_rdata_bo); end
        n_chk++; if (m1_resp_o !== 1'b0 || m1_rdata_bo !== 32'h0) begin n_fail++; $display("FAIL t1_m1quiet got %b %h want 0 0", m1_resp_o, m1_rdata_bo); end
        cyc();
        idle();
        smp();
        n_chk++; if (outstanding_bo !== 3'd0 || m0_resp_o !== 1'b0 || m0_rdata_bo !== 32'h0) begin n_fail++; $display("FAIL t1_done got outst=%0d resp=%b rdata=%h want 0 0 0", outstanding_bo, m0_resp_o, m0_rdata_bo); end
    endtask

    task automatic test_two_masters();
        cyc();
        m0_req_i = 1; m0_addr_bi = 32'h10; m1_req_i = 1; m1_addr_bi = 32'h20; s_ack_i = 1;
        smp();
        n_chk++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_addr_bo !== 32'h10) begin n_fail++; $display("FAIL t2_first got %b%b addr=%h want 10 addr=10", m0_ack_o, m1_ack_o, s_addr_bo); end
        cyc();
        m0_req_i = 0;
        smp();
        n_chk++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b1 || s_addr_bo !== 32'h20) begin n_fail++; $display("FAIL t2_second got %b%b addr=%h want 01 addr=20", m0_ack_o, m1_ack_o, s_addr_bo); end
        cyc();
        idle();
        s_resp_i = 1; s_rdata_bi = 32'hA;
        smp();
        n_chk++; if (outstanding_bo !== 3'd2) begin n_fail++; $display("FAIL t2_outst got %0d want 2", outstanding_bo); end
        n_chk++; if (m0_resp_o !== 1'b1 || m0_rdata_bo !== 32'hA || m1_resp_o !== 1'b0) begin n_fail++; $display("FAIL t2_respA got m0=%b %h m1=%b want 1 a 0", m0_resp_o, m0_rdata_bo, m1_resp_o); end
        cyc();
        s_rdata_bi = 32'hB;
        smp();
        n_chk++; if (m1_resp_o !== 1'b1 || m1_rdata_bo !== 32'hB || m0_resp_o !== 1'b0 || m0_rdata_bo !== 32'h0) begin n_fail++; $display("FAIL t2_respB got m1=%b %h m0=%b %h want 1 b 0 0", m1_resp_o, m1_rdata_bo, m0_resp_o, m0_rdata_bo); end
        cyc();
        idle();
        smp();
        n_chk++; if (outstanding_bo !== 3'd0) begin n_fail++; $display("FAIL t2_drain got %0d want 0", outstanding_bo); end
    endtask

    task automatic test_starvation();
        cyc();
        m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h300;
        m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h400; s_ack_i = 1;
        for (int k = 1; k <= 10; k++) begin
            smp();
            n_chk++;
            if (m0_ack_o !== (k != 9) || m1_ack_o !== (k == 9)) begin
                n_fail++; $display("FAIL t3_grant_%0d got %b%b want %b%b", k, m0_ack_o, m1_ack_o, k != 9, k == 9);
            end
            cyc();
        end
        idle();
        smp();
        n_chk++; if (outstanding_bo !== 3'd0) begin n_fail++; $display("FAIL t3_nopush got %0d want 0", outstanding_bo); end
    endtask

    task automatic test_fifo_full();
        cyc();
        m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h500; s_ack_i = 1;
        for (int k = 0; k < 4; k++) begin
            smp();
            n_chk++; if (m1_ack_o !== 1'b1) begin n_fail++; $display("FAIL t4_fill_%0d got %b want 1", k, m1_ack_o); end
            cyc();
        end
        smp();
        n_chk++; if (s_req_o !== 1'b0 || m1_ack_o !== 1'b0 || outstanding_bo !== 3'd4) begin n_fail++; $display("FAIL t4_block got req=%b ack=%b outst=%0d want 0 0 4", s_req_o, m1_ack_o, outstanding_bo); end
        cyc();
        m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h200;
        smp();
        n_chk++; if (m0_ack_o !== 1'b1 || s_we_o !== 1'b1 || s_addr_bo !== 32'h200 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL t4_write got ack=%b we=%b addr=%h m1ack=%b want 1 1 200 0", m0_ack_o, s_we_o, s_addr_bo, m1_ack_o); end
        cyc();
        m0_req_i = 0; m0_we_i = 0;
        s_resp_i = 1; s_rdata_bi = 32'h11;
        smp();
        n_chk++; if (s_req_o !== 1'b0 || m1_resp_o !== 1'b1 || m1_rdata_bo !== 32'h11) begin n_fail++; $display("FAIL t4_popblock got req=%b resp=%b rdata=%h want 0 1 11", s_req_o, m1_resp_o, m1_rdata_bo); end
        cyc();
        s_resp_i = 0;
        smp();
        n_chk++; if (m1_ack_o !== 1'b1 || outstanding_bo !== 3'd3) begin n_fail++; $display("FAIL t4_reissue got ack=%b outst=%0d want 1 3", m1_ack_o, outstanding_bo); end
        cyc();
        idle();
        s_resp_i = 1;
        for (int k = 0; k < 4; k++) begin
            s_rdata_bi = 32'h20 + k;
            smp();
            n_chk++; if (m1_resp_o !== 1'b1 || m1_rdata_bo !== 32'h20 + k || m0_resp_o !== 1'b0) begin n_fail++; $display("FAIL t4_drain_%0d got m1=%b %h m0=%b", k, m1_resp_o, m1_rdata_bo, m0_resp_o); end
            cyc();
        end
        idle();
        smp();
        n_chk++; if (outstanding_bo !== 3'd0 || err_o !== 1'b0) begin n_fail++; $display("FAIL t4_empty got outst=%0d err=%b want 0 0", outstanding_bo, err_o); end
    endtask

    task automatic test_orphan();
        cyc();
        s_resp_i = 1; s_rdata_bi = 32'h55;
        smp();
        n_chk++; if (m0_resp_o !== 1'b0 || m1_resp_o !== 1'b0 || m0_rdata_bo !== 32'h0 || m1_rdata_bo !== 32'h0) begin n_fail++; $display("FAIL t5_drop got %b%b %h %h want 00 0 0", m0_resp_o, m1_resp_o, m0_rdata_bo, m1_rdata_bo); end
        cyc();
        idle();
        smp();
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL t5_err got %b want 1", err_o); end
        cyc(); cyc(); cyc();
        smp();
        n_chk++; if (err_o !== 1'b1 || outstanding_bo !== 3'd0) begin n_fail++; $display("FAIL t5_sticky got err=%b outst=%0d want 1 0", err_o, outstanding_bo); end
        cyc();
        arst_n_i = 0;
        smp();
        n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL t5_clear got %b want 0", err_o); end
        cyc();
        arst_n_i = 1;
    endtask

    task automatic test_reset_mid();
        cyc();
        m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h600; s_ack_i = 1;
        cyc();
        cyc();
        idle();
        smp();
        n_chk++; if (outstanding_bo !== 3'd2) begin n_fail++; $display("FAIL t6_outst got %0d want 2", outstanding_bo); end
        cyc();
        m0_req_i = 1; m0_addr_bi = 32'h604; s_ack_i = 1;
        arst_n_i = 0;
        smp();
        n_chk++; if (outstanding_bo !== 3'd0 || s_req_o !== 1'b0 || m0_ack_o !== 1'b0 || s_addr_bo !== 32'h0) begin n_fail++; $display("FAIL t6_rst got outst=%0d req=%b ack=%b addr=%h want 0 0 0 0", outstanding_bo, s_req_o, m0_ack_o, s_addr_bo); end
        cyc();
        idle();
        arst_n_i = 1;
        cyc();
        s_resp_i = 1; s_rdata_bi = 32'h77;
        smp();
        n_chk++; if (m0_resp_o !== 1'b0 || m1_resp_o !== 1'b0) begin n_fail++; $display("FAIL t6_late got %b%b want 00", m0_resp_o, m1_resp_o); end
        cyc();
        idle();
        smp();
        n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL t6_err got %b want 1", err_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_two_masters();
        test_starvation();
        test_fifo_full();
        test_orphan();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
